// File: rtl/dcache_assoc_pkg.sv
// Shared types and helpers for the set-associative data cache line store.
// Holds the flush walk states and the line-address set/tag split.
package dcache_assoc_pkg;

    typedef enum logic [1:0] {
        FL_IDLE = 2'd0,
        FL_WALK = 2'd1,
        FL_DONE = 2'd2
    } flush_state_e;

    // Low set_bits of a line address select the set.
    function automatic logic [31:0] addr_set(input logic [31:0] addr, input int unsigned set_bits);
        return addr & ((32'd1 << set_bits) - 32'd1);
    endfunction

    // Everything above the set index is the tag.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int unsigned set_bits);
        return addr >> set_bits;
    endfunction

endpackage

// File: rtl/dcache_assoc_if.sv
// Request / response / eviction bundle of the data cache line store.
// The flush handshake exists only when DCACHE_ASSOC_FLUSH_EN is defined.
interface dcache_assoc_if #(
    parameter int unsigned addr_width = 16,
    parameter int unsigned line_width = 64
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_write_i;
    logic [addr_width-1:0] addr_i;
    logic                  dirty_i;
    logic [line_width-1:0] write_i;
    logic                  resp_valid_o;
    logic                  hit_o;
    logic [line_width-1:0] read_o;
    logic                  evict_valid_o;
    logic [addr_width-1:0] evict_addr_o;
    logic [line_width-1:0] evict_o;
`ifdef DCACHE_ASSOC_FLUSH_EN
    logic                  flush_i;
    logic                  flush_done_o;

    modport master (
        output req_valid_i, req_write_i, addr_i, dirty_i, write_i, flush_i,
        input  req_ready_o, resp_valid_o, hit_o, read_o,
               evict_valid_o, evict_addr_o, evict_o, flush_done_o
    );
    modport slave (
        input  req_valid_i, req_write_i, addr_i, dirty_i, write_i, flush_i,
        output req_ready_o, resp_valid_o, hit_o, read_o,
               evict_valid_o, evict_addr_o, evict_o, flush_done_o
    );
`else
    modport master (
        output req_valid_i, req_write_i, addr_i, dirty_i, write_i,
        input  req_ready_o, resp_valid_o, hit_o, read_o,
               evict_valid_o, evict_addr_o, evict_o
    );
    modport slave (
        input  req_valid_i, req_write_i, addr_i, dirty_i, write_i,
        output req_ready_o, resp_valid_o, hit_o, read_o,
               evict_valid_o, evict_addr_o, evict_o
    );
`endif
endinterface

// File: rtl/dcache_assoc_victim.sv
// Victim way selection: lowest-index invalid way, otherwise the set's
// round-robin pointer, which advances on every write miss.
module dcache_assoc_victim #(
    parameter int unsigned sets = 32,
    parameter int unsigned ways = 2,
    localparam int unsigned set_bits = $clog2(sets),
    localparam int unsigned way_bits = (ways > 1) ? $clog2(ways) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [set_bits-1:0] set_i,
    input  logic [ways-1:0]     valid_i,
    input  logic                advance_i,
    output logic [way_bits-1:0] victim_o
);
    logic [way_bits-1:0] rr_q [sets];
    logic [way_bits-1:0] rr_d [sets];

    // Downward scan so the lowest invalid way is the last to win.
    always_comb begin
        victim_o = rr_q[set_i];
        for (int w = ways - 1; w >= 0; w--) begin
            if (!valid_i[w]) begin
                victim_o = way_bits'(w);
            end else begin
                victim_o = victim_o;
            end
        end
    end

    // Pointer advance with wrap at the last way.
    always_comb begin
        rr_d = rr_q;
        if (advance_i) begin
            if (rr_q[set_i] == way_bits'(ways - 1)) begin
                rr_d[set_i] = '0;
            end else begin
                rr_d[set_i] = rr_q[set_i] + way_bits'(1);
            end
        end else begin
            rr_d = rr_q;
        end
    end

    // Pointer storage.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < sets; i++) begin
                rr_q[i] <= '0;
            end
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/dcache_assoc.sv
// Set-associative write-back line store: accept in cycle 0, compare/respond/update in cycle 1.
// Optional flush walk enabled by DCACHE_ASSOC_FLUSH_EN.
module dcache_assoc
    import dcache_assoc_pkg::*;
#(
    parameter int unsigned addr_width = 16,
    parameter int unsigned line_width = 64,
    parameter int unsigned sets       = 32,
    parameter int unsigned ways       = 2
) (
    input logic           clk_i,
    input logic           rst_ni,
    dcache_assoc_if.slave bus
);
    localparam int unsigned set_bits = $clog2(sets);
    localparam int unsigned tag_bits = addr_width - set_bits;
    localparam int unsigned way_bits = (ways > 1) ? $clog2(ways) : 1;

    typedef struct packed {
        logic                  valid;
        logic                  dirty;
        logic [tag_bits-1:0]   tag;
        logic [line_width-1:0] data;
    } line_t;

    line_t lines_q [sets][ways];
    line_t lines_d [sets][ways];

    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_write_q, s1_write_d;
    logic [addr_width-1:0] s1_addr_q,  s1_addr_d;
    logic                  s1_dirty_q, s1_dirty_d;
    logic [line_width-1:0] s1_data_q,  s1_data_d;
    logic [addr_width-1:0] hold_addr_q, hold_addr_d;
    logic [line_width-1:0] hold_data_q, hold_data_d;
    logic                  fl_evict_q, fl_evict_d;

    logic                  req_ready_s, accept_s, active_s;
    logic [set_bits-1:0]   s1_set_s;
    logic [tag_bits-1:0]   s1_tag_s;
    logic [ways-1:0]       set_valid_s;
    logic                  hit_s, wr_miss_s, s1_evict_s;
    logic [way_bits-1:0]   hit_way_s, victim_way_s, tgt_way_s;
    line_t                 victim_line_s, fl_line_s;
    logic                  fl_walk_s;
    logic [set_bits-1:0]   fl_set_s;
    logic [way_bits-1:0]   fl_way_s;

`ifdef DCACHE_ASSOC_FLUSH_EN
    flush_state_e        fl_state_q, fl_state_d;
    logic [set_bits-1:0] fl_set_q, fl_set_d;
    logic [way_bits-1:0] fl_way_q, fl_way_d;

    // Walk every (set, way) once, then a single done cycle.
    always_comb begin
        fl_state_d = fl_state_q;
        fl_set_d   = fl_set_q;
        fl_way_d   = fl_way_q;
        case (fl_state_q)
            FL_IDLE: begin
                if (bus.flush_i) begin
                    fl_state_d = FL_WALK;
                    fl_set_d   = '0;
                    fl_way_d   = '0;
                end else begin
                    fl_state_d = FL_IDLE;
                end
            end
            FL_WALK: begin
                if (fl_way_q == way_bits'(ways - 1)) begin
                    fl_way_d = '0;
                    if (fl_set_q == set_bits'(sets - 1)) begin
                        fl_state_d = FL_DONE;
                    end else begin
                        fl_set_d = fl_set_q + set_bits'(1);
                    end
                end else begin
                    fl_way_d = fl_way_q + way_bits'(1);
                end
            end
            FL_DONE: fl_state_d = FL_IDLE;
            default: fl_state_d = FL_IDLE;
        endcase
    end

    // Flush walk registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fl_state_q <= FL_IDLE;
            fl_set_q   <= '0;
            fl_way_q   <= '0;
        end else begin
            fl_state_q <= fl_state_d;
            fl_set_q   <= fl_set_d;
            fl_way_q   <= fl_way_d;
        end
    end

    // Blocking intake in the flush_i cycle lets the in-flight request finish first.
    assign req_ready_s      = (fl_state_q == FL_IDLE) && !bus.flush_i;
    assign fl_walk_s        = (fl_state_q == FL_WALK);
    assign fl_set_s         = fl_set_q;
    assign fl_way_s         = fl_way_q;
    assign bus.flush_done_o = rst_ni && (fl_state_q == FL_DONE);
`else
    assign req_ready_s = 1'b1;
    assign fl_walk_s   = 1'b0;
    assign fl_set_s    = '0;
    assign fl_way_s    = '0;
`endif

    assign accept_s = bus.req_valid_i && req_ready_s;
    assign active_s = s1_valid_q && rst_ni;
    assign s1_set_s = set_bits'(addr_set(32'(s1_addr_q), set_bits));
    assign s1_tag_s = tag_bits'(addr_tag(32'(s1_addr_q), set_bits));

    // Stage-1 request capture.
    always_comb begin
        s1_valid_d = accept_s;
        if (accept_s) begin
            s1_write_d = bus.req_write_i;
            s1_addr_d  = bus.addr_i;
            s1_dirty_d = bus.dirty_i;
            s1_data_d  = bus.write_i;
        end else begin
            s1_write_d = s1_write_q;
            s1_addr_d  = s1_addr_q;
            s1_dirty_d = s1_dirty_q;
            s1_data_d  = s1_data_q;
        end
    end

    // Tag compare against the array state left by the previous request, which gives the bypass for free.
    always_comb begin
        hit_s       = 1'b0;
        hit_way_s   = '0;
        set_valid_s = '0;
        for (int w = 0; w < ways; w++) begin
            set_valid_s[w] = lines_q[s1_set_s][w].valid;
            if (lines_q[s1_set_s][w].valid && (lines_q[s1_set_s][w].tag == s1_tag_s)) begin
                hit_s     = 1'b1;
                hit_way_s = way_bits'(w);
            end else begin
                hit_s = hit_s;
            end
        end
    end

    assign wr_miss_s     = active_s && s1_write_q && !hit_s;
    assign tgt_way_s     = hit_s ? hit_way_s : victim_way_s;
    assign victim_line_s = lines_q[s1_set_s][victim_way_s];
    assign s1_evict_s    = wr_miss_s && victim_line_s.valid && victim_line_s.dirty;
    assign fl_line_s     = lines_q[fl_set_s][fl_way_s];
    assign fl_evict_d    = fl_walk_s && rst_ni && fl_line_s.valid && fl_line_s.dirty;

    dcache_assoc_victim #(
        .sets (sets),
        .ways (ways)
    ) u_victim (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .set_i     (s1_set_s),
        .valid_i   (set_valid_s),
        .advance_i (wr_miss_s),
        .victim_o  (victim_way_s)
    );

    // Array update: request write in cycle 1, or dirty clear for a flushed line.
    always_comb begin
        lines_d = lines_q;
        if (active_s && s1_write_q) begin
            lines_d[s1_set_s][tgt_way_s].valid = 1'b1;
            lines_d[s1_set_s][tgt_way_s].dirty = hit_s ? (lines_q[s1_set_s][tgt_way_s].dirty | s1_dirty_q)
                                                       : s1_dirty_q;
            lines_d[s1_set_s][tgt_way_s].tag   = s1_tag_s;
            lines_d[s1_set_s][tgt_way_s].data  = s1_data_q;
        end else begin
            lines_d = lines_q;
        end
        if (fl_evict_d) begin
            lines_d[fl_set_s][fl_way_s].dirty = 1'b0;
        end else begin
            lines_d = lines_d;
        end
    end

    // Evict address/data hold their last value between pulses.
    always_comb begin
        if (s1_evict_s) begin
            hold_addr_d = {victim_line_s.tag, s1_set_s};
            hold_data_d = victim_line_s.data;
        end else if (fl_evict_d) begin
            hold_addr_d = {fl_line_s.tag, fl_set_s};
            hold_data_d = fl_line_s.data;
        end else begin
            hold_addr_d = hold_addr_q;
            hold_data_d = hold_data_q;
        end
    end

    // Pipeline, array and output-hold registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q  <= 1'b0;
            s1_write_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_dirty_q  <= 1'b0;
            s1_data_q   <= '0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            fl_evict_q  <= 1'b0;
            for (int i = 0; i < sets; i++) begin
                for (int w = 0; w < ways; w++) begin
                    lines_q[i][w] <= '0;
                end
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_write_q  <= s1_write_d;
            s1_addr_q   <= s1_addr_d;
            s1_dirty_q  <= s1_dirty_d;
            s1_data_q   <= s1_data_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            fl_evict_q  <= fl_evict_d;
            lines_q     <= lines_d;
        end
    end

    assign bus.req_ready_o   = rst_ni && req_ready_s;
    assign bus.resp_valid_o  = active_s && !s1_write_q;
    assign bus.hit_o         = active_s && !s1_write_q && hit_s;
    assign bus.read_o        = (active_s && !s1_write_q && hit_s) ? lines_q[s1_set_s][hit_way_s].data : '0;
    assign bus.evict_valid_o = s1_evict_s || (fl_evict_q && rst_ni);
    assign bus.evict_addr_o  = !rst_ni ? '0 : (s1_evict_s ? {victim_line_s.tag, s1_set_s} : hold_addr_q);
    assign bus.evict_o       = !rst_ni ? '0 : (s1_evict_s ? victim_line_s.data : hold_data_q);

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc: lookups, bypass, round-robin eviction, reset drop
// and, when DCACHE_ASSOC_FLUSH_EN is defined, the flush walk.
module tb_dcache_assoc;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    dcache_assoc_if #(.addr_width(16), .line_width(64)) bus ();

    dcache_assoc #(
        .addr_width (16),
        .line_width (64),
        .sets       (32),
        .ways       (2)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Outputs seen right after a drive belong to the request driven one call earlier.
    task automatic drive(input logic v, input logic w, input logic [15:0] a,
                         input logic d, input logic [63:0] data);
        @(negedge clk);
        bus.req_valid_i = v;
        bus.req_write_i = w;
        bus.addr_i      = a;
        bus.dirty_i     = d;
        bus.write_i     = data;
    endtask

    task automatic rd(input logic [15:0] a);
        drive(1'b1, 1'b0, a, 1'b0, 64'h0);
    endtask

    task automatic wr(input logic [15:0] a, input logic d, input logic [63:0] data);
        drive(1'b1, 1'b1, a, d, data);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 64'h0);
    endtask

`ifdef DCACHE_ASSOC_FLUSH_EN
    // Pulse flush_i and watch the walk for a bounded number of cycles.
    task automatic run_flush(output int n_ev, output int done_c,
                             output logic [15:0] a0, output logic [15:0] a1, output logic [15:0] a2,
                             output logic [63:0] d0, output logic [63:0] d1, output logic [63:0] d2);
        n_ev = 0; done_c = 0;
        a0 = 16'h0; a1 = 16'h0; a2 = 16'h0;
        d0 = 64'h0; d1 = 64'h0; d2 = 64'h0;
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check_eq("ready_in_flush", bus.req_ready_o, 1'b0);
        for (int c = 1; c <= 200 && done_c == 0; c++) begin
            if (bus.evict_valid_o) begin
                if (n_ev == 0) begin a0 = bus.evict_addr_o; d0 = bus.evict_o; end
                if (n_ev == 1) begin a1 = bus.evict_addr_o; d1 = bus.evict_o; end
                if (n_ev == 2) begin a2 = bus.evict_addr_o; d2 = bus.evict_o; end
                n_ev++;
            end
            if (bus.flush_done_o) done_c = c;
            @(negedge clk);
        end
    endtask
`endif

    initial begin
`ifdef DCACHE_ASSOC_FLUSH_EN
        int n_ev, done_c;
        logic [15:0] a0, a1, a2;
        logic [63:0] d0, d1, d2;
        bus.flush_i = 1'b0;
`endif
        rst_n           = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.req_write_i = 1'b0;
        bus.addr_i      = 16'h0;
        bus.dirty_i     = 1'b0;
        bus.write_i     = 64'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_resp_valid", bus.resp_valid_o, 1'b0);
        check_eq("rst_hit", bus.hit_o, 1'b0);
        check_eq("rst_evict_valid", bus.evict_valid_o, 1'b0);
        check_eq("rst_evict_addr", bus.evict_addr_o, 16'h0);
        check_eq("rst_read", bus.read_o, 64'h0);
        rst_n = 1'b1;
        idle();
        check_eq("ready_after_rst", bus.req_ready_o, 1'b1);

        // Cold miss.
        rd(16'h0010);
        idle();
        check_eq("cold_resp_valid", bus.resp_valid_o, 1'b1);
        check_eq("cold_hit", bus.hit_o, 1'b0);
        check_eq("cold_read", bus.read_o, 64'h0);
        check_eq("cold_evict", bus.evict_valid_o, 1'b0);

        // Write then immediate read of the same line.
        wr(16'h0010, 1'b1, 64'hAA);
        rd(16'h0010);
        check_eq("wr_no_resp", bus.resp_valid_o, 1'b0);
        check_eq("wr_no_evict", bus.evict_valid_o, 1'b0);
        idle();
        check_eq("bypass_resp", bus.resp_valid_o, 1'b1);
        check_eq("bypass_hit", bus.hit_o, 1'b1);
        check_eq("bypass_read", bus.read_o, 64'hAA);

        // Set 5: two fills, then round-robin victims 0x0005 and 0x0025.
        wr(16'h0005, 1'b1, 64'h55);
        wr(16'h0025, 1'b1, 64'h66);
        check_eq("fill0_evict", bus.evict_valid_o, 1'b0);
        wr(16'h0045, 1'b1, 64'h77);
        check_eq("fill1_evict", bus.evict_valid_o, 1'b0);
        wr(16'h0065, 1'b1, 64'h88);
        check_eq("ev1_valid", bus.evict_valid_o, 1'b1);
        check_eq("ev1_addr", bus.evict_addr_o, 16'h0005);
        check_eq("ev1_data", bus.evict_o, 64'h55);
        rd(16'h0045);
        check_eq("ev2_valid", bus.evict_valid_o, 1'b1);
        check_eq("ev2_addr", bus.evict_addr_o, 16'h0025);
        check_eq("ev2_data", bus.evict_o, 64'h66);
        rd(16'h0005);
        check_eq("ev_pulse_end", bus.evict_valid_o, 1'b0);
        check_eq("ev_addr_hold", bus.evict_addr_o, 16'h0025);
        check_eq("rd45_hit", bus.hit_o, 1'b1);
        check_eq("rd45_read", bus.read_o, 64'h77);
        rd(16'h0065);
        check_eq("rd05_miss", bus.hit_o, 1'b0);
        idle();
        check_eq("rd65_read", bus.read_o, 64'h88);

        // Set 7: clean fill, in-place rewrite, clean victim on conflict.
        wr(16'h0007, 1'b0, 64'h11);
        wr(16'h0007, 1'b0, 64'h22);
        rd(16'h0007);
        check_eq("rewrite_no_evict", bus.evict_valid_o, 1'b0);
        wr(16'h0027, 1'b0, 64'h33);
        check_eq("inplace_read", bus.read_o, 64'h22);
        wr(16'h0047, 1'b1, 64'h44);
        rd(16'h0007);
        check_eq("clean_victim_evict", bus.evict_valid_o, 1'b0);
        rd(16'h0047);
        check_eq("victim_gone", bus.hit_o, 1'b0);
        rd(16'h0027);
        check_eq("rd47_read", bus.read_o, 64'h44);
        idle();
        check_eq("rd27_read", bus.read_o, 64'h33);

        // Reset right behind a dirty conflicting write drops it.
        wr(16'h0009, 1'b1, 64'h99);
        wr(16'h0029, 1'b1, 64'h9A);
        wr(16'h0049, 1'b1, 64'h9B);
        idle();
        rst_n = 1'b0;
        #1;
        check_eq("rst_drop_evict", bus.evict_valid_o, 1'b0);
        check_eq("rst_drop_addr", bus.evict_addr_o, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(16'h0009);
        rd(16'h0049);
        check_eq("post_rst_resp", bus.resp_valid_o, 1'b1);
        check_eq("post_rst_0009", bus.hit_o, 1'b0);
        rd(16'h0010);
        check_eq("post_rst_0049", bus.hit_o, 1'b0);
        idle();
        check_eq("post_rst_0010", bus.hit_o, 1'b0);
        check_eq("post_rst_evict", bus.evict_valid_o, 1'b0);

`ifdef DCACHE_ASSOC_FLUSH_EN
        // Dirty lines in sets 1, 4, 9 plus one clean line.
        wr(16'h0001, 1'b1, 64'hA1);
        wr(16'h0024, 1'b1, 64'hA4);
        wr(16'h0009, 1'b1, 64'hA9);
        wr(16'h0002, 1'b0, 64'hA2);
        idle();
        idle();
        run_flush(n_ev, done_c, a0, a1, a2, d0, d1, d2);
        check_eq("flush_n_evict", n_ev, 3);
        check_eq("flush_done_cycle", done_c, 65);
        check_eq("flush_ev0_addr", a0, 16'h0001);
        check_eq("flush_ev1_addr", a1, 16'h0024);
        check_eq("flush_ev2_addr", a2, 16'h0009);
        check_eq("flush_ev0_data", d0, 64'hA1);
        check_eq("flush_ev2_data", d2, 64'hA9);
        run_flush(n_ev, done_c, a0, a1, a2, d0, d1, d2);
        check_eq("reflush_n_evict", n_ev, 0);
        check_eq("reflush_done_cycle", done_c, 65);
        idle();
        check_eq("ready_after_flush", bus.req_ready_o, 1'b1);
        rd(16'h0024);
        idle();
        check_eq("flush_keeps_valid", bus.hit_o, 1'b1);
        check_eq("flush_keeps_data", bus.read_o, 64'hA4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
